shift_issue_stage: RTL and testbench

SHIFT_ISSUE_STAGE -- requirements
Module: shift_issue_stage

---
 rtl/shift_pkg.sv | 23 ++
 rtl/shift_issue_fifo.sv | 81 ++++++++
 rtl/shift_issue_stage.sv | 75 +++++++
 tb/tb_shift_issue_stage.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shared types and constants for the shift issue stage
package shift_pkg;

   localparam int DEFAULT_WIDTH = 64;
   localparam int DEFAULT_SHW   = $clog2(DEFAULT_WIDTH);

   typedef enum logic [1:0] {SLL = 2'd0, SRL = 2'd1, SLA = 2'd2, SRA = 2'd3} shift_op_t;

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} fifo_state_t;

   typedef struct packed {
      logic [DEFAULT_WIDTH-1:0] data;
      logic [DEFAULT_SHW-1:0]   shamt;
      shift_op_t                op;
      logic                     fill;
   } issue_entry_t;

   // Arithmetic ops replicate the sign bit into vacated positions; logical ops use zero.
   function automatic logic fill_of(input shift_op_t op, input logic msb);
      return (op == SLA || op == SRA) ? msb : 1'b0;
   endfunction

endpackage

// File: rtl/shift_issue_fifo.sv
// shift_issue_fifo: generic 2-entry skid FIFO, oldest entry presented, zero output when empty
module shift_issue_fifo
   import shift_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [DW-1:0] i_data,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [DW-1:0] o_data,
   output logic          o_push
);

   fifo_state_t   r_state, w_state;
   logic [DW-1:0] r_head, r_tail, w_head, w_tail;
   logic          w_push, w_pop;

   assign o_ready = (r_state != FULL);
   assign o_valid = (r_state != EMPTY);
   assign o_data  = o_valid ? r_head : '0;
   assign w_push  = i_valid && o_ready && !flush;
   assign w_pop   = o_valid && i_ready && !flush;
   assign o_push  = w_push;

   // State, head (oldest) and tail registers; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= EMPTY;
         r_head  <= '0;
         r_tail  <= '0;
      end else begin
         r_state <= w_state;
         r_head  <= w_head;
         r_tail  <= w_tail;
      end
   end

   // Next-state and storage update; flush wins over any push or pop in the same cycle.
   always_comb begin
      w_state = r_state;
      w_head  = r_head;
      w_tail  = r_tail;
      if (flush) begin
         w_state = EMPTY;
         w_head  = '0;
         w_tail  = '0;
      end else begin
         case (r_state)
            EMPTY: if (w_push) begin
               w_state = ONE;
               w_head  = i_data;
            end
            ONE: if (w_push && w_pop) begin
               w_head = i_data;
            end else if (w_push) begin
               w_state = FULL;
               w_tail  = i_data;
            end else if (w_pop) begin
               w_state = EMPTY;
               w_head  = '0;
            end
            FULL: if (w_pop) begin
               w_state = ONE;
               w_head  = r_tail;
               w_tail  = '0;
            end
            default: begin
               w_state = EMPTY;
               w_head  = '0;
               w_tail  = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/shift_issue_stage.sv
// shift_issue_stage: decode/fill generation in front of a 2-entry skid FIFO; SHIFT_ISSUE_STATS_EN adds counters
module shift_issue_stage
   import shift_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shamt,
   input  shift_op_t        in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [SHW-1:0]   out_sig,
   output shift_op_t        out_op,
   output logic             out_fill
`ifdef SHIFT_ISSUE_STATS_EN
   ,
   output logic [31:0]      stat_accepted,
   output logic [31:0]      stat_stall
`endif
);

   localparam int EW = WIDTH + SHW + 3;

   logic [EW-1:0] w_in, w_out;
   logic          w_push;

   assign w_in = {in_data, in_shamt, in_op, fill_of(in_op, in_data[WIDTH-1])};

   shift_issue_fifo #(.DW(EW)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .i_valid (in_valid),
      .o_ready (in_ready),
      .i_data  (w_in),
      .o_valid (out_valid),
      .i_ready (out_ready),
      .o_data  (w_out),
      .o_push  (w_push)
   );

   assign out_data = w_out[EW-1 -: WIDTH];
   assign out_sig  = w_out[SHW+2 -: SHW];
   assign out_op   = shift_op_t'(w_out[2:1]);
   assign out_fill = w_out[0];

`ifdef SHIFT_ISSUE_STATS_EN
   logic [31:0] r_accepted, r_stall;

   assign stat_accepted = r_accepted;
   assign stat_stall    = r_stall;

   // Free-running wrap-around counters of accepted pushes and backpressured cycles; flush-independent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_accepted <= '0;
         r_stall    <= '0;
      end else begin
         r_accepted <= r_accepted + {31'd0, w_push};
         r_stall    <= r_stall + {31'd0, out_valid && !out_ready};
      end
   end
`else
   logic w_unused;
   assign w_unused = w_push;
`endif

endmodule

// File: tb/tb_shift_issue_stage.sv
// tb_shift_issue_stage: directed self-checking bench for shift_issue_stage
module tb_shift_issue_stage;
   import shift_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_data = '0;
   logic [5:0]  in_shamt = '0;
   shift_op_t   in_op = SLL;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_data;
   logic [5:0]  out_sig;
   shift_op_t   out_op;
   logic        out_fill;
   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_d;

   shift_issue_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sig   (out_sig),
      .out_op    (out_op),
      .out_fill  (out_fill)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] d, input logic [5:0] s, input shift_op_t o, input logic r);
      in_valid  = v;
      in_data   = d;
      in_shamt  = s;
      in_op     = o;
      out_ready = r;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_out_sig", {58'd0, out_sig}, 64'd0);
      rst_n = 1'b1;
      drive(1'b1, 64'h8000_0000_0000_0001, 6'd5, SLA, 1'b1);
      tick();
      drive(1'b0, 64'd0, 6'd0, SLL, 1'b1);
      chk("sla_valid", {63'd0, out_valid}, 64'd1);
      chk("sla_sig", {58'd0, out_sig}, 64'd5);
      chk("sla_fill", {63'd0, out_fill}, 64'd1);
      chk("sla_data", out_data, 64'h8000_0000_0000_0001);
      chk("sla_op", {62'd0, out_op}, 64'd2);
      tick();
      chk("pop_empty_valid", {63'd0, out_valid}, 64'd0);
      chk("pop_empty_data", out_data, 64'd0);
      chk("pop_empty_fill", {63'd0, out_fill}, 64'd0);
      drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0, SLL, 1'b0);
      tick();
      chk("z_valid", {63'd0, out_valid}, 64'd1);
      chk("z_sig", {58'd0, out_sig}, 64'd0);
      chk("z_fill", {63'd0, out_fill}, 64'd0);
      chk("z_data", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
      drive(1'b0, 64'd0, 6'd0, SLL, 1'b1);
      tick();
      chk("z_drain", {63'd0, out_valid}, 64'd0);
      drive(1'b1, 64'd1, 6'd1, SLL, 1'b0);
      tick();
      chk("bp1_ready", {63'd0, in_ready}, 64'd1);
      chk("bp1_data", out_data, 64'd1);
      drive(1'b1, 64'd2, 6'd2, SRL, 1'b0);
      tick();
      chk("bp2_ready", {63'd0, in_ready}, 64'd0);
      chk("bp2_data", out_data, 64'd1);
      drive(1'b1, 64'd3, 6'd3, SRA, 1'b0);
      tick();
      chk("bp3_ready", {63'd0, in_ready}, 64'd0);
      chk("bp3_data", out_data, 64'd1);
      chk("bp3_sig", {58'd0, out_sig}, 64'd1);
      chk("bp3_op", {62'd0, out_op}, 64'd0);
      out_ready = 1'b1;
      tick();
      chk("full_pop_data", out_data, 64'd2);
      chk("full_pop_op", {62'd0, out_op}, 64'd1);
      chk("full_pop_ready", {63'd0, in_ready}, 64'd1);
      tick();
      chk("held_c_data", out_data, 64'd3);
      chk("held_c_sig", {58'd0, out_sig}, 64'd3);
      for (int i = 0; i < 10; i++) begin
         exp_d = {i[0], 63'd0} | 64'(100 + i);
         drive(1'b1, exp_d, 6'(i), SRA, 1'b1);
         tick();
         chk("pp_valid", {63'd0, out_valid}, 64'd1);
         chk("pp_ready", {63'd0, in_ready}, 64'd1);
         chk("pp_data", out_data, exp_d);
         chk("pp_fill", {63'd0, out_fill}, {63'd0, i[0]});
      end
      drive(1'b1, 64'hD, 6'd7, SLL, 1'b0);
      tick();
      chk("refill_ready", {63'd0, in_ready}, 64'd0);
      flush = 1'b1;
      drive(1'b1, 64'hE, 6'd8, SLL, 1'b0);
      tick();
      flush = 1'b0;
      drive(1'b0, 64'd0, 6'd0, SLL, 1'b0);
      chk("flush_valid", {63'd0, out_valid}, 64'd0);
      chk("flush_ready", {63'd0, in_ready}, 64'd1);
      chk("flush_data", out_data, 64'd0);
      tick();
      chk("flush_lost", {63'd0, out_valid}, 64'd0);
      drive(1'b1, 64'hA1, 6'd1, SLL, 1'b0);
      tick();
      drive(1'b1, 64'hA2, 6'd2, SLL, 1'b0);
      tick();
      drive(1'b0, 64'd0, 6'd0, SLL, 1'b0);
      chk("pre_rst_full", {63'd0, in_ready}, 64'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", {63'd0, out_valid}, 64'd0);
      chk("arst_ready", {63'd0, in_ready}, 64'd1);
      chk("arst_data", out_data, 64'd0);
      #2 rst_n = 1'b1;
      drive(1'b1, 64'hF00D, 6'd4, SRL, 1'b0);
      tick();
      drive(1'b0, 64'd0, 6'd0, SLL, 1'b0);
      chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
      chk("post_rst_data", out_data, 64'hF00D);
      chk("post_rst_sig", {58'd0, out_sig}, 64'd4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
